// File: rtl/bus_rr_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | bus_rr_arbiter_pkg : shared constants for the round-robin arbiter  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package bus_rr_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int CNT_W = 4;
  localparam int SEL_W = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bus_rr_arbiter_rr_pick4.sv
// +--------------------------------------------------------------------+
// | rr_pick4 : combinational rotating-priority pick, search from ptr+1 |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_pick4
  import bus_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] w_cand;

  // Walk from lowest priority (ptr itself) up to ptr+1 so the last hit wins.
  always_comb begin
    win    = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_cand = ptr + i[SEL_W-1:0];
      if (req[w_cand]) begin
        win         = '0;
        win[w_cand] = 1'b1;
        idx         = w_cand;
        any         = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux4_16.sv
// +--------------------------------------------------------------------+
// | mux4_16$ : library 4:1 16-bit mux cell, select is {S1,S0}          |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module mux4_16$ (
  input  logic [15:0] IN0,
  input  logic [15:0] IN1,
  input  logic [15:0] IN2,
  input  logic [15:0] IN3,
  input  logic        S0,
  input  logic        S1,
  output logic [15:0] Y
);

  always_comb begin
    case ({S1, S0})
      2'd0:    Y = IN0;
      2'd1:    Y = IN1;
      2'd2:    Y = IN2;
      default: Y = IN3;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
// +--------------------------------------------------------------------+
// | bus_rr_arbiter : 4-way round-robin bus owner with hold timeout     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD  = 8,
  parameter int RESET_PTR = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ-1:0]  DONE,
  input  logic [15:0]      IN0,
  input  logic [15:0]      IN1,
  input  logic [15:0]      IN2,
  input  logic [15:0]      IN3,
  output logic [NREQ-1:0]  GNT,
  output logic [SEL_W-1:0] SEL,
  output logic [15:0]      BUS_OUT,
  output logic             BUS_VALID
);

  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0] c_reset_ptr = SEL_W'(RESET_PTR);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic [SEL_W-1:0] r_sel;
  logic [15:0]      r_bus;
  logic             r_valid;

  logic             w_rel_done;
  logic             w_release;
  logic [NREQ-1:0]  w_pick_req;
  logic [NREQ-1:0]  w_win;
  logic [SEL_W-1:0] w_idx;
  logic             w_any;
  logic [15:0]      w_mux_y;

  // A finishing owner is masked out so it cannot immediately win again;
  // a timed-out owner keeps its request and simply drops to last place.
  assign w_rel_done = DONE[r_sel];
  assign w_release  = w_rel_done | ~REQ[r_sel] | (r_cnt == c_hold_last);
  assign w_pick_req = (r_state == ST_OWN) ? (REQ & ~(w_rel_done ? r_gnt : '0)) : REQ;

  rr_pick4 u_pick (
    .req (w_pick_req),
    .ptr (r_ptr),
    .win (w_win),
    .idx (w_idx),
    .any (w_any)
  );

  mux4_16$ u_mux (
    .IN0 (IN0),
    .IN1 (IN1),
    .IN2 (IN2),
    .IN3 (IN3),
    .S0  (r_sel[0]),
    .S1  (r_sel[1]),
    .Y   (w_mux_y)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= c_reset_ptr;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_bus   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_bus   <= w_mux_y;
      r_valid <= |r_gnt;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_sel   <= w_idx;
            r_ptr   <= w_idx;
            r_cnt   <= '0;
            r_state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (w_release) begin
            if (w_any) begin
              r_gnt <= w_win;
              r_sel <= w_idx;
              r_ptr <= w_idx;
              r_cnt <= '0;
            end else begin
              r_gnt   <= '0;
              r_state <= ST_IDLE;
            end
          end else if (r_cnt != c_hold_last) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign GNT       = r_gnt;
  assign SEL       = r_sel;
  assign BUS_OUT   = r_bus;
  assign BUS_VALID = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_bus_rr_arbiter : directed scoreboard bench for bus_rr_arbiter   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_bus_rr_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ;
  logic [3:0]  DONE;
  logic [15:0] IN0, IN1, IN2, IN3;
  logic [3:0]  GNT;
  logic [1:0]  SEL;
  logic [15:0] BUS_OUT;
  logic        BUS_VALID;

  typedef struct {
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        valid;
    logic [15:0] bout;
    int          id;
  } exp_t;

  exp_t        q[$];
  logic [15:0] din[4];
  logic [3:0]  prev_gnt;
  logic [1:0]  prev_sel;
  int          vec_id;
  int          checks;
  int          errors;

  bus_rr_arbiter #(.MAX_HOLD(8), .RESET_PTR(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .DONE      (DONE),
    .IN0       (IN0),
    .IN1       (IN1),
    .IN2       (IN2),
    .IN3       (IN3),
    .GNT       (GNT),
    .SEL       (SEL),
    .BUS_OUT   (BUS_OUT),
    .BUS_VALID (BUS_VALID)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, id, act, expv);
    end
  endtask

  // Scoreboard monitor: one expectation per clock edge, checked on the falling edge.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt",       e.id, {12'd0, GNT},       {12'd0, e.gnt});
      chk("sel",       e.id, {14'd0, SEL},       {14'd0, e.sel});
      chk("bus_valid", e.id, {15'd0, BUS_VALID}, {15'd0, e.valid});
      chk("bus_out",   e.id, BUS_OUT,            e.bout);
    end
  end

  // Drive one cycle of inputs and queue what must appear after the next edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic [3:0] eg, input logic [1:0] es);
    exp_t e;
    @(negedge CLK);
    #1;
    REQ     = r;
    DONE    = d;
    e.gnt   = eg;
    e.sel   = es;
    e.valid = |prev_gnt;
    e.bout  = din[prev_sel];
    e.id    = vec_id;
    vec_id++;
    q.push_back(e);
    prev_gnt = eg;
    prev_sel = es;
  endtask

  // Reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string nm);
    @(negedge CLK);
    #1;
    REQ  = 4'b0000;
    DONE = 4'b0000;
    RST  = 1'b1;
    #1;
    chk({nm, "_gnt"},   -1, {12'd0, GNT},       16'd0);
    chk({nm, "_sel"},   -1, {14'd0, SEL},       16'd0);
    chk({nm, "_bus"},   -1, BUS_OUT,            16'd0);
    chk({nm, "_valid"}, -1, {15'd0, BUS_VALID}, 16'd0);
    #1;
    RST      = 1'b0;
    prev_gnt = 4'b0000;
    prev_sel = 2'd0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    vec_id   = 0;
    prev_gnt = 4'b0000;
    prev_sel = 2'd0;
    IN0 = 16'hA5A5; IN1 = 16'h1111; IN2 = 16'h2222; IN3 = 16'h3C3C;
    din[0] = 16'hA5A5; din[1] = 16'h1111; din[2] = 16'h2222; din[3] = 16'h3C3C;
    REQ  = 4'b0000;
    DONE = 4'b0000;
    RST  = 1'b1;
    #2;
    chk("rst_gnt",   -1, {12'd0, GNT},       16'd0);
    chk("rst_valid", -1, {15'd0, BUS_VALID}, 16'd0);
    chk("rst_bus",   -1, BUS_OUT,            16'd0);
    RST = 1'b0;

    // Reset priority then full rotation 0,1,2,3,0
    cyc(4'b1111, 4'b0000, 4'b0001, 2'd0);
    cyc(4'b1111, 4'b0000, 4'b0001, 2'd0);
    cyc(4'b1111, 4'b0001, 4'b0010, 2'd1);
    cyc(4'b1111, 4'b0000, 4'b0010, 2'd1);
    cyc(4'b1111, 4'b0010, 4'b0100, 2'd2);
    cyc(4'b1111, 4'b0000, 4'b0100, 2'd2);
    cyc(4'b1111, 4'b0100, 4'b1000, 2'd3);
    cyc(4'b1111, 4'b0000, 4'b1000, 2'd3);
    cyc(4'b1111, 4'b1000, 4'b0001, 2'd0);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd0);

    // Timeout: owner 0 holds exactly 8 cycles, then requester 1
    do_reset("rst2");
    for (int i = 0; i < 8; i++) cyc(4'b0011, 4'b0000, 4'b0001, 2'd0);
    cyc(4'b0011, 4'b0000, 4'b0010, 2'd1);

    // Lone requester 2 is re-granted across timeouts without a gap
    cyc(4'b0100, 4'b0000, 4'b0100, 2'd2);
    for (int i = 0; i < 16; i++) cyc(4'b0100, 4'b0000, 4'b0100, 2'd2);

    // Non-owner DONE / REQ activity ignored, then owner drops to idle
    cyc(4'b0110, 4'b0001, 4'b0100, 2'd2);
    cyc(4'b0100, 4'b0001, 4'b0100, 2'd2);
    cyc(4'b0110, 4'b0000, 4'b0100, 2'd2);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd2);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd2);

    // Async reset while requester 1 owns the bus
    cyc(4'b0010, 4'b0000, 4'b0010, 2'd1);
    cyc(4'b0010, 4'b0000, 4'b0010, 2'd1);
    do_reset("rst3");
    cyc(4'b1111, 4'b0000, 4'b0001, 2'd0);
    cyc(4'b1111, 4'b0000, 4'b0001, 2'd0);

    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 16-bit 4:1 bus mux. Four requesters compete for the bus. The block owns the mux select lines (S1,S0), issues one-hot grants, enforces a maximum hold time, and registers the selected data onto the shared bus. It sits between the requesting units and the library 4:1 16-bit mux cell (mux4_16$), which it instantiates and drives.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles per owner before forced release (legal range 1-15)
RESET_PTR, 3, last-owner pointer value at reset; default makes requester 0 highest priority first

Ports:
CLK  input  1  single clock, all state updates on rising edge
RST  input  1  asynchronous, active-high reset
REQ  input  4  request per requester; level-sensitive, held while bus wanted
DONE  input  4  one-cycle release strobe per requester; only the owner's bit counts
IN0  input  16  requester 0 data
IN1  input  16  requester 1 data
IN2  input  16  requester 2 data
IN3  input  16  requester 3 data
GNT  output  4  registered one-hot grant; all zero when idle
SEL  output  2  registered mux select {S1,S0} = index of owner; holds last value when idle
BUS_OUT  output  16  registered mux output
BUS_VALID  output  1  registered; high when BUS_OUT carries owner data

Behaviour:
- Reset (async, immediate, including mid-grant): GNT=0, SEL=0, BUS_OUT=0, BUS_VALID=0, state=IDLE, hold counter=0, pointer=RESET_PTR.
- FSM states: IDLE, OWN.
- Priority: rotating. Search order starts at pointer+1 mod 4 and wraps. The pointer updates to the new owner index on every grant.
- IDLE: if |REQ at an edge, pick the winner, set GNT one-hot, set SEL to its index, clear the counter, and go to OWN. Otherwise stay in IDLE.
- OWN release conditions, evaluated each edge:
  - DONE[owner]=1, or
  - REQ[owner]=0, or
  - counter==MAX_HOLD-1.
- Release with other requests pending: re-arbitrate in the same edge with no idle bubble; the new owner's GNT is asserted the next cycle. The released owner is lowest priority, so it is re-granted only if nothing else is pending. This includes the timeout case.
- Release with nothing pending (owner's REQ=0 after masking): GNT=0, go to IDLE, SEL unchanged.
- No release: counter +1; it saturates and never wraps past MAX_HOLD-1.
- Simultaneous release conditions (DONE, REQ drop, timeout) in one cycle: a single release; no double pointer advance.
- DONE or REQ changes from non-owners are ignored for the current grant.
- DONE while IDLE is ignored.
- Data path: the mux4_16$ instance is driven by registered SEL. On each edge, BUS_OUT <= mux output and BUS_VALID <= |GNT. Data therefore lags grant by one cycle.
  - Latency: REQ high before edge N -> GNT at edge N -> BUS_OUT/BUS_VALID at edge N+1.
- When idle, BUS_OUT keeps capturing the mux output but BUS_VALID=0; consumers must qualify on BUS_VALID.
- X on SEL is not reachable after reset. Mux delays are within one cycle and need no extra staging.

Decomposition:
- Shared package constants:
  - NREQ=4.
  - State encodings IDLE=1'b0, OWN=1'b1.
  - Counter width 4.
  - SEL width 2.
- Sub-module rr_pick4: combinational. Inputs: 4-bit request vector and 2-bit pointer. Outputs: one-hot winner, 2-bit index, any flag. Used by both IDLE arbitration and OWN re-arbitration.
- The mux4_16$ cell is instantiated directly; no wrapper.

Test Plan:
- Reset priority: RST pulse, then REQ=4'b1111 -> GNT=4'b0001 next cycle, SEL=0. BUS_OUT=IN0 (e.g. 16'hA5A5) and BUS_VALID=1 one cycle later.
- Rotation: REQ=1111 throughout with DONE pulsed by each owner after 2 cycles -> grant sequence 0,1,2,3,0 with no idle cycle between owners.
- Timeout: REQ=4'b0011, owner 0 never sends DONE, MAX_HOLD=8 -> GNT switches 0001->0010 after exactly 8 grant cycles.
- Timeout lone requester: REQ=4'b0100 held -> GNT=0100 continuously, counter clears every 8 cycles, BUS_VALID stays 1.
- Ignore non-owner: owner 2 granted, DONE=4'b0001 and REQ[1] toggling -> GNT stays 0100. REQ[2] drop with REQ=0 elsewhere -> GNT=0 next cycle, BUS_VALID=0 the following cycle, SEL holds 2.
- Async reset mid-grant: RST asserted between edges while GNT=0010 -> GNT, BUS_OUT and BUS_VALID go to 0 immediately without a clock edge. After release, REQ=1111 -> grant to requester 0.
